// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side logic: read-stream state encoding and default word width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer between the FIFO pop side and a valid/ready stream.
// Latency: 1 cycle push to head_vld; head_dat comes straight from a register.
// Backpressure: holds up to two words; push is accepted only while space exists or a word leaves that cycle.
module fifo_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             head_vld,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       occ_q;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        pop_ok  = pop_vld && (occ_q != 2'd0);
        push_ok = push_vld && ((occ_q != 2'd2) || pop_ok);
    end

    // The head advances from the tail on a pop; an incoming word lands in whichever slot
    // becomes the youngest after that pop.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            if (pop_ok && (occ_q == 2'd2)) begin
                head_q <= tail_q;
            end
            if (push_ok) begin
                if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop_ok)) begin
                    head_q <= push_dat;
                end else begin
                    tail_q <= push_dat;
                end
            end
            occ_q <= occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign head_dat = head_q;
    assign head_vld = (occ_q != 2'd0);
    assign occ      = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a first-word-fall-through FIFO read port into a valid/ready stream and counts pops.
// Latency: first pop 1 cycle after en is sampled, first m_valid 1 cycle after that; 1 word/cycle sustained.
// Backpressure: m_ready stalls via a 2-entry buffer; pops stop when it is full, with no m_ready->rinc path.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             en,
    input  logic             rempty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] pop_cnt,
    output logic             busy
);

    rd_state_e        state_q;
    rd_state_e        state_d;
    logic [1:0]       occ;
    logic [CNT_W-1:0] pop_cnt_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Re-enabling during DRAIN takes priority over finishing the drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (occ == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Depends only on registered state and occupancy plus the FIFO flag, never on m_ready.
    assign rinc = (state_q == ST_RUN) && !rempty && (occ != 2'd2);
    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pop_cnt_q <= '0;
        end else if (rinc) begin
            pop_cnt_q <= pop_cnt_q + CNT_W'(1);
        end
    end

    assign pop_cnt = pop_cnt_q;

    fifo_skid_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .push_vld (rinc),
        .push_dat (rdata),
        .pop_vld  (m_ready),
        .head_dat (m_data),
        .head_vld (m_valid),
        .occ      (occ)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue plays the FIFO, a word-list model predicts the stream.
module tb_fifo_rd_stream;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       en;
    logic       rempty;
    logic [7:0] rdata;
    logic       m_ready;
    logic       rinc,  rinc4;
    logic [7:0] m_data, m_data4;
    logic       m_valid, m_valid4;
    logic [15:0] pop_cnt;
    logic [3:0]  pop_cnt4;
    logic       busy, busy4;

    int checks = 0;
    int errors = 0;

    logic [7:0] fq[$];
    logic [7:0] mq[$];
    logic [7:0] rd_log[$];
    logic [7:0] wr_log[$];
    logic [7:0] pre [8] = '{8'd77, 8'd79, 8'd72, 8'd65, 8'd77, 8'd77, 8'd69, 8'd68};

    bit gate;
    int st_m;
    int pops, xfers, cyc;
    int last_x, run_len, max_run;
    int first_pop, first_x;
    int viol_rinc, viol_valid, viol_data, viol_busy, viol_cnt;

    always #5 rclk = ~rclk;

    fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) u_dut (
        .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .pop_cnt(pop_cnt), .busy(busy)
    );

    fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .en(en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .pop_cnt(pop_cnt4), .busy(busy4)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic clear_model();
        st_m = 0; pops = 0; xfers = 0;
        mq.delete(); rd_log.delete(); wr_log.delete();
        last_x = -10; run_len = 0; max_run = 0;
        first_pop = -1; first_x = -1;
        viol_rinc = 0; viol_valid = 0; viol_data = 0; viol_busy = 0; viol_cnt = 0;
    endtask

    task automatic do_reset();
        en = 1'b0; m_ready = 1'b0; gate = 1'b0;
        fq.delete();
        rempty = 1'b1; rdata = 8'h00;
        rrst_n = 1'b0;
        @(negedge rclk);
        rrst_n = 1'b1;
        clear_model();
    endtask

    task automatic preload8();
        for (int i = 0; i < 8; i++) begin
            fq.push_back(pre[i]);
            wr_log.push_back(pre[i]);
        end
    endtask

    // One clock: drive FIFO flags, tally invariant deviations, advance FIFO and stream model.
    task automatic run_cycle();
        bit exp_rinc, r_s, xf;
        int occ;
        rempty = (fq.size() == 0) || gate;
        rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
        #1;
        occ = mq.size();
        exp_rinc = (st_m == 1) && !rempty && (occ < 2);
        if (rinc !== exp_rinc || rinc4 !== exp_rinc) viol_rinc++;
        if (m_valid !== (occ != 0)) viol_valid++;
        if (occ != 0 && m_data !== mq[0]) viol_data++;
        if (busy !== (st_m != 0)) viol_busy++;
        if (pop_cnt !== pops[15:0] || pop_cnt4 !== pops[3:0]) viol_cnt++;
        r_s = rinc;
        xf  = (occ != 0) && m_ready;
        @(posedge rclk);
        if (xf) begin
            rd_log.push_back(mq.pop_front());
            xfers++;
            if (first_x < 0) first_x = cyc;
            run_len = (last_x == cyc - 1) ? run_len + 1 : 1;
            if (run_len > max_run) max_run = run_len;
            last_x = cyc;
        end
        if (r_s && fq.size() != 0) begin
            mq.push_back(fq.pop_front());
            pops++;
            if (first_pop < 0) first_pop = cyc;
        end
        case (st_m)
            0: if (en) st_m = 1;
            1: if (!en) st_m = 2;
            default: if (en) st_m = 1; else if (occ == 0) st_m = 0;
        endcase
        cyc++;
        @(negedge rclk);
    endtask

    task automatic check_viol(input string name);
        checks++;
        if ((viol_rinc + viol_valid + viol_data + viol_busy + viol_cnt) != 0) begin
            errors++;
            $display("FAIL %s invariants: rinc=%0d valid=%0d data=%0d busy=%0d cnt=%0d deviations, required 0",
                     name, viol_rinc, viol_valid, viol_data, viol_busy, viol_cnt);
        end
    endtask

    task automatic drain_idle(input string name);
        int n;
        en = 1'b0; m_ready = 1'b1;
        n = 0;
        while (st_m != 0 && n < 20) begin
            run_cycle();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s drain_to_idle: busy=%0b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        en = 1'b1; m_ready = 1'b1; rempty = 1'b0; rdata = 8'hA5; gate = 1'b0;
        rrst_n = 1'b0;
        #3;
        checks++;
        if ({rinc, m_valid, busy} !== 3'b000 || m_data !== 8'h00 || pop_cnt !== 16'h0 || pop_cnt4 !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: rinc=%0b m_valid=%0b busy=%0b m_data=%0d pop_cnt=%0d, required all 0",
                     rinc, m_valid, busy, m_data, pop_cnt);
        end
        @(negedge rclk); @(negedge rclk);
        checks++;
        if (busy !== 1'b0 || rinc !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: busy=%0b rinc=%0b with en=1 in reset, required 0", busy, rinc);
        end
        do_reset();
        cyc = 0;
        en = 1'b1; m_ready = 1'b0;
        run_cycle();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: busy=%0b after first edge with en=1, required 1", busy);
        end
        check_viol("reset");
    endtask

    task automatic test_stream();
        int c0;
        do_reset();
        preload8();
        en = 1'b1; m_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 14; i++) run_cycle();
        checks++;
        if (first_pop !== c0 + 1 || first_x !== c0 + 2) begin
            errors++;
            $display("FAIL stream_latency: first pop cycle %0d, first transfer cycle %0d, required %0d and %0d",
                     first_pop - c0, first_x - c0, 1, 2);
        end
        checks++;
        if (xfers !== 8 || max_run < 8) begin
            errors++;
            $display("FAIL stream_rate: %0d transfers, longest run %0d, required 8 and 8", xfers, max_run);
        end
        checks++;
        if (pop_cnt !== 16'd8) begin
            errors++;
            $display("FAIL stream_pop_cnt: pop_cnt=%0d, required 8", pop_cnt);
        end
        checks++;
        if (rempty !== 1'b1 || rinc !== 1'b0) begin
            errors++;
            $display("FAIL stream_empty_stop: rempty=%0b rinc=%0b, required 1 and 0", rempty, rinc);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= rd_log.size() || rd_log[i] !== pre[i]) begin
                errors++;
                $display("FAIL stream_order[%0d]: got %0d, required %0d", i,
                         (i < rd_log.size()) ? rd_log[i] : 8'hxx, pre[i]);
            end
        end
        drain_idle("stream");
        check_viol("stream");
    endtask

    task automatic test_backpressure();
        do_reset();
        preload8();
        en = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 8; i++) run_cycle();
        checks++;
        if (pops !== 2 || pop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL bp_pops: model pops=%0d pop_cnt=%0d, required 2", pops, pop_cnt);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'd77 || u_dut.u_buf.occ_q !== 2'd2) begin
            errors++;
            $display("FAIL bp_hold: m_valid=%0b m_data=%0d occ=%0d, required 1, 77, 2",
                     m_valid, m_data, u_dut.u_buf.occ_q);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) run_cycle();
        checks++;
        if (rd_log.size() !== 8) begin
            errors++;
            $display("FAIL bp_count: %0d words delivered, required 8", rd_log.size());
        end
        for (int i = 0; i < 8 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== pre[i]) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %0d, required %0d", i, rd_log[i], pre[i]);
            end
        end
        drain_idle("bp");
        check_viol("bp");
    endtask

    task automatic test_drain();
        int n, x_hold;
        do_reset();
        preload8();
        n = 0;
        while (n < 20) begin
            en = (pops < 3);
            m_ready = (xfers < 1);
            run_cycle();
            n++;
            if (!en) break;
        end
        checks++;
        if (busy !== 1'b1 || st_m !== 2 || pops !== 3) begin
            errors++;
            $display("FAIL drain_enter: busy=%0b model state=%0d pops=%0d, required 1, DRAIN, 3", busy, st_m, pops);
        end
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) run_cycle();
        checks++;
        if (pop_cnt !== 16'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_no_pop: pop_cnt=%0d busy=%0b, required 3 and 1", pop_cnt, busy);
        end
        x_hold = xfers;
        drain_idle("drain");
        checks++;
        if (xfers - x_hold !== 2 || pop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL drain_deliver: %0d words after release, pop_cnt=%0d, required 2 and 3",
                     xfers - x_hold, pop_cnt);
        end
        for (int i = 0; i < 3 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== pre[i]) begin
                errors++;
                $display("FAIL drain_order[%0d]: got %0d, required %0d", i, rd_log[i], pre[i]);
            end
        end
        check_viol("drain");
    endtask

    task automatic test_cnt_wrap();
        logic [7:0] w;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            w = 8'($urandom);
            fq.push_back(w);
            wr_log.push_back(w);
        end
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 25; i++) run_cycle();
        checks++;
        if (pop_cnt4 !== 4'd1 || pop_cnt !== 16'd17) begin
            errors++;
            $display("FAIL cnt_wrap: pop_cnt(4b)=%0d pop_cnt(16b)=%0d, required 1 and 17", pop_cnt4, pop_cnt);
        end
        drain_idle("cnt_wrap");
        check_viol("cnt_wrap");
    endtask

    task automatic test_reset_mid();
        do_reset();
        preload8();
        en = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 5; i++) run_cycle();
        checks++;
        if (m_valid !== 1'b1 || u_dut.u_buf.occ_q !== 2'd2 || st_m !== 1) begin
            errors++;
            $display("FAIL rmid_setup: m_valid=%0b occ=%0d, required 1 and 2", m_valid, u_dut.u_buf.occ_q);
        end
        rempty = 1'b0;
        #2 rrst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, rinc, busy} !== 3'b000 || pop_cnt !== 16'd0 || m_data !== 8'd0) begin
            errors++;
            $display("FAIL rmid_async: m_valid=%0b rinc=%0b busy=%0b pop_cnt=%0d m_data=%0d, required all 0",
                     m_valid, rinc, busy, pop_cnt, m_data);
        end
        @(negedge rclk);
        rrst_n = 1'b1;
        clear_model();
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 12; i++) run_cycle();
        checks++;
        if (rd_log.size() !== 6 || pop_cnt !== 16'd6) begin
            errors++;
            $display("FAIL rmid_resume: %0d words delivered, pop_cnt=%0d, required 6 and 6", rd_log.size(), pop_cnt);
        end
        for (int i = 0; i < 6 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== pre[i + 2]) begin
                errors++;
                $display("FAIL rmid_order[%0d]: got %0d, required %0d", i, rd_log[i], pre[i + 2]);
            end
        end
        drain_idle("rmid");
        check_viol("rmid");
    endtask

    task automatic test_random();
        int nw, n;
        logic [7:0] w;
        do_reset();
        en = 1'b1;
        nw = 0; n = 0;
        while ((nw < 40 || rd_log.size() < 40) && n < 600) begin
            if (nw < 40 && $urandom_range(0, 1) == 1) begin
                w = 8'($urandom);
                fq.push_back(w);
                wr_log.push_back(w);
                nw++;
            end
            gate = ~gate;
            m_ready = 1'($urandom_range(0, 1));
            run_cycle();
            n++;
        end
        gate = 1'b0;
        checks++;
        if (rd_log.size() !== 40 || pops !== 40) begin
            errors++;
            $display("FAIL rand_count: %0d delivered, %0d popped, required 40 and 40", rd_log.size(), pops);
        end
        for (int i = 0; i < 40 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== wr_log[i]) begin
                errors++;
                $display("FAIL rand_order[%0d]: got %0d, required %0d", i, rd_log[i], wr_log[i]);
            end
        end
        drain_idle("rand");
        check_viol("rand");
    endtask

    initial begin
        rrst_n = 1'b0; en = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = 8'h00; gate = 1'b0;
        clear_model();
        cyc = 0;
        @(negedge rclk);
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_cnt_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
